// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Optional behaviour in fetch_unit is selected by the FETCH_MISALIGN_EN macro.
package fetch_pkg;

  localparam int unsigned FETCH_DATA_W = 32;
  localparam int unsigned FETCH_ADDR_W = 13;
  localparam int unsigned PC_STEP      = 4;

  localparam logic [FETCH_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  // Clear the two byte-offset bits of a byte address.
  function automatic logic [FETCH_ADDR_W-1:0] align_pc(input logic [FETCH_ADDR_W-1:0] addr);
    return {addr[FETCH_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; flush wins over push, and a full queue
// accepts a push in the same cycle as a pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  fetch_entry_t       data_i,
  output fetch_entry_t       head_c_o,
  output logic               full_c_o,
  output logic               empty_c_o,
  output logic [CNT_W-1:0]   count_o
);

  fetch_entry_t       mem_q [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full_c_o  = (count_q == CNT_W'(QDEPTH));
  assign empty_c_o = (count_q == '0);
  assign head_c_o  = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  assign do_pop  = pop_i & ~empty_c_o & ~flush_i;
  assign do_push = push_i & (~full_c_o | do_pop) & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty entries are never presented.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC mux and decode handshake.
// Define FETCH_MISALIGN_EN to halt and flag on misaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FETCH_DATA_W,
  parameter int unsigned ADDR_WIDTH = FETCH_ADDR_W,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_raddr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  misalign_err
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  halted;
  logic                  deq, enq;
  logic                  q_full, q_empty;
  logic [CNT_W-1:0]      q_count;
  fetch_entry_t          q_head, q_in;
  logic                  unused_count;

  assign unused_count = ^q_count;

  assign imem_raddr  = pc_q;
  assign instr_valid = ~q_empty;
  assign instr_data  = q_empty ? DATA_WIDTH'(NOP_INSTR) : DATA_WIDTH'(q_head.instr);
  assign instr_pc    = q_empty ? '0 : ADDR_WIDTH'(q_head.pc);

  assign deq = instr_valid & instr_ready;
  assign enq = ~redirect_valid & ~halted & (~q_full | deq);

  assign q_in.pc    = FETCH_ADDR_W'(pc_q);
  assign q_in.instr = FETCH_DATA_W'(imem_rdata);

  // Redirect beats sequential fetch; the PC holds when stalled or halted.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)
      pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    else if (enq)
      pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= ADDR_WIDTH'(RESET_PC);
    else     pc_q <= pc_d;
  end

`ifdef FETCH_MISALIGN_EN
  logic halted_q, halted_d;
  logic misalign_q, misalign_d;
  logic target_misaligned;

  assign target_misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);

  // Any redirect re-evaluates the halt; only reset clears the sticky flag.
  always_comb begin
    halted_d   = halted_q;
    misalign_d = misalign_q | target_misaligned;
    if (redirect_valid) halted_d = target_misaligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  assign halted       = halted_q;
  assign misalign_err = misalign_q;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign halted               = 1'b0;
  assign misalign_err         = 1'b0;
`endif

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push_i    (enq),
    .pop_i     (deq),
    .flush_i   (redirect_valid),
    .data_i    (q_in),
    .head_c_o  (q_head),
    .full_c_o  (q_full),
    .empty_c_o (q_empty),
    .count_o   (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit; the instruction ROM returns a fixed
// function of the byte address so expected words follow from the PC alone.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] imem_raddr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [12:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [12:0] instr_pc;
  logic        misalign_err;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [12:0] addr);
    return 32'hC0DE_0000 ^ {19'd0, addr};
  endfunction

  assign imem_rdata = rom(imem_raddr);

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_raddr     (imem_raddr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [12:0] pc);
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_pc"},    32'(instr_pc),    32'(pc));
    check({tag, "_data"},  instr_data,       rom(pc));
  endtask

  initial begin
    rst            = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();

    check("rst_valid",  32'(instr_valid),  32'd0);
    check("rst_data",   instr_data,        32'h0000_0013);
    check("rst_pc",     32'(instr_pc),     32'd0);
    check("rst_raddr",  32'(imem_raddr),   32'd0);
    check("rst_misal",  32'(misalign_err), 32'd0);

    // Steady streaming from reset
    rst = 1'b0;
    check("t1_first_empty", 32'(instr_valid), 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      expect_head("t1_stream", 13'(4 * i));
      tick();
    end

    // Backpressure fills the queue and freezes the PC
    rst         = 1'b1;
    instr_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_head("t2_hold", 13'h000);
    end
    check("t2_raddr_frozen", 32'(imem_raddr), 32'h8);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_head("t2_drain", 13'(4 * i));
      tick();
    end

    // Redirect with a full queue
    instr_ready = 1'b0;
    tick();
    expect_head("t3_full", 13'h010);
    check("t3_raddr_full", 32'(imem_raddr), 32'h18);
    redirect_valid = 1'b1;
    redirect_pc    = 13'h0100;
    tick();
    redirect_valid = 1'b0;
    check("t3_flushed", 32'(instr_valid), 32'd0);
    check("t3_raddr",   32'(imem_raddr),  32'h100);
    tick();
    expect_head("t3_target", 13'h100);
    instr_ready = 1'b1;
    tick();
    expect_head("t3_next", 13'h104);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 13'h1FF8;
    tick();
    redirect_valid = 1'b0;
    check("t4_flushed", 32'(instr_valid), 32'd0);
    tick();
    expect_head("t4_1ff8", 13'h1FF8);
    tick();
    expect_head("t4_1ffc", 13'h1FFC);
    tick();
    expect_head("t4_wrap", 13'h0000);

    // Redirect concurrent with a dequeue
    redirect_valid = 1'b1;
    redirect_pc    = 13'h0400;
    tick();
    redirect_valid = 1'b0;
    check("t5_flushed", 32'(instr_valid), 32'd0);
    tick();
    expect_head("t5_target", 13'h400);
    tick();
    expect_head("t5_next", 13'h404);

    // Back-to-back redirects: the last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 13'h0300;
    tick();
    check("b2b_first", 32'(instr_valid), 32'd0);
    redirect_pc = 13'h0340;
    tick();
    redirect_valid = 1'b0;
    check("b2b_second", 32'(instr_valid), 32'd0);
    check("b2b_raddr",  32'(imem_raddr),  32'h340);
    tick();
    expect_head("b2b_target", 13'h340);

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 13'h0102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_EN
    check("t6_misal_set", 32'(misalign_err), 32'd1);
    check("t6_raddr",     32'(imem_raddr),   32'h100);
    tick();
    tick();
    tick();
    check("t6_halted_valid", 32'(instr_valid),  32'd0);
    check("t6_halted_raddr", 32'(imem_raddr),   32'h100);
    redirect_valid = 1'b1;
    redirect_pc    = 13'h0200;
    tick();
    redirect_valid = 1'b0;
    check("t6_resume_empty", 32'(instr_valid), 32'd0);
    tick();
    expect_head("t6_resume", 13'h200);
    check("t6_misal_sticky", 32'(misalign_err), 32'd1);
`else
    check("t6_misal_tied", 32'(misalign_err), 32'd0);
    check("t6_raddr",      32'(imem_raddr),   32'h100);
    tick();
    expect_head("t6_truncated", 13'h100);
    check("t6_misal_still0", 32'(misalign_err), 32'd0);
`endif

    // Reset mid-stream with a full queue
    instr_ready = 1'b0;
    tick();
    tick();
    check("rst_mid_full_valid", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_valid", 32'(instr_valid),  32'd0);
    check("rst_mid_data",  instr_data,        32'h0000_0013);
    check("rst_mid_pc",    32'(instr_pc),     32'd0);
    check("rst_mid_raddr", 32'(imem_raddr),   32'd0);
    check("rst_mid_misal", 32'(misalign_err), 32'd0);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
